// File: rtl/pipe_stage_skid.sv
// Pipeline stage register with valid/ready handshake and a two-entry skid buffer.
// in_ready is decoded from registered state, so out_ready never reaches upstream combinationally.
module pipe_stage_skid #(
  parameter int DATA_W = 96,
  parameter int CNT_W  = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  input  logic              flush,
  input  logic              stat_clr,
  output logic [1:0]        occupancy,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  flush_cnt
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    TWO   = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [DATA_W-1:0] main_q, main_d;
  logic [DATA_W-1:0] skid_q, skid_d;
  logic              accept, retire, stall;
  logic [1:0]        flush_inc;

  assign in_ready  = (state_q != TWO);
  assign out_valid = (state_q != EMPTY);
  assign occupancy = state_q;
  assign out_data  = main_q;

  assign accept    = in_valid & in_ready;
  assign retire    = out_valid & out_ready;
  assign stall     = out_valid & ~out_ready & ~flush;
  // The attempted accept counts as discarded even when in_ready is low.
  assign flush_inc = occupancy + {1'b0, in_valid};

  function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a,
                                               input logic [1:0]       b);
    logic [CNT_W:0] s;
    s = {1'b0, a} + {{(CNT_W-1){1'b0}}, b};
    return s[CNT_W] ? {CNT_W{1'b1}} : s[CNT_W-1:0];
  endfunction

  always_comb begin
    // NOTE: every signal gets a hold default first so no path can infer a latch.
    state_d = state_q;
    main_d  = main_q;
    skid_d  = skid_q;
    if (flush) begin
      state_d = EMPTY;
      main_d  = '0;
      skid_d  = '0;
    end else begin
      unique case (state_q)
        EMPTY: if (accept) begin
          main_d  = in_data;
          state_d = ONE;
        end
        ONE: begin
          if (accept && retire) begin
            main_d = in_data;
          end else if (accept) begin
            skid_d  = in_data;
            state_d = TWO;
          end else if (retire) begin
            main_d  = '0;
            state_d = EMPTY;
          end
        end
        TWO: if (retire) begin
          main_d  = skid_q;
          skid_d  = '0;
          state_d = ONE;
        end
        default: begin
          state_d = EMPTY;
          main_d  = '0;
          skid_d  = '0;
        end
      endcase
    end
  end

  // NOTE: payload registers are reset too, because out_data must read zero whenever out_valid is low.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= EMPTY;
      main_q  <= '0;
      skid_q  <= '0;
    end else begin
      // NOTE: non-blocking assignments so every register samples pre-edge values.
      state_q <= state_d;
      main_q  <= main_d;
      skid_q  <= skid_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else if (stat_clr) begin
      stall_cnt <= '0;
      flush_cnt <= '0;
    end else begin
      if (stall) stall_cnt <= sat_add(stall_cnt, 2'd1);
      if (flush) flush_cnt <= sat_add(flush_cnt, flush_inc);
    end
  end

endmodule

// File: tb/tb_pipe_stage_skid.sv
// Directed + random bench for pipe_stage_skid; a negedge monitor checks against a FIFO scoreboard.
// A second instance with CNT_W=2 shares the stimulus to exercise counter saturation.
module tb_pipe_stage_skid;
  localparam int DW = 16;

  logic          clk = 1'b0;
  logic          rst, in_valid, out_ready, flush, stat_clr;
  logic [DW-1:0] in_data;
  logic          in_ready, out_valid;
  logic [DW-1:0] out_data;
  logic [1:0]    occupancy;
  logic [15:0]   stall_cnt, flush_cnt;

  logic          s_in_ready, s_out_valid;
  logic [DW-1:0] s_out_data;
  logic [1:0]    s_occupancy, s_stall_cnt, s_flush_cnt;

  int total = 0;
  int bad   = 0;

  logic [DW-1:0] q[$];
  int stall_m = 0, flush_m = 0, stall_sat_m = 0;

  always #5 clk = ~clk;

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(16)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .flush(flush),
    .stat_clr(stat_clr), .occupancy(occupancy), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
  );

  pipe_stage_skid #(.DATA_W(DW), .CNT_W(2)) dut_sat (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(s_in_ready), .in_data(in_data),
    .out_valid(s_out_valid), .out_ready(out_ready), .out_data(s_out_data), .flush(flush),
    .stat_clr(stat_clr), .occupancy(s_occupancy), .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
  );

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [DW-1:0] d, input logic ordy,
                       input logic fl, input logic clr);
    in_valid  = v;
    in_data   = d;
    out_ready = ordy;
    flush     = fl;
    stat_clr  = clr;
  endtask

  // Scoreboard monitor: compare current outputs, then advance the model with this cycle's inputs.
  always @(negedge clk) begin
    int  sz, add;
    bit  acc, ret, stl;
    if (rst) begin
      q.delete();
      stall_m = 0; flush_m = 0; stall_sat_m = 0;
    end else begin
      sz = q.size();
      check("occupancy", 64'(occupancy), 64'(sz));
      check("in_ready", 64'(in_ready), 64'(sz < 2));
      check("out_valid", 64'(out_valid), 64'(sz != 0));
      if (sz == 0) check("out_data_idle", 64'(out_data), 64'd0);
      check("stall_cnt", 64'(stall_cnt), 64'(stall_m));
      check("flush_cnt", 64'(flush_cnt), 64'(flush_m));
      check("stall_sat", 64'(s_stall_cnt), 64'(stall_sat_m));
      acc = in_valid && (sz < 2);
      ret = (sz != 0) && out_ready;
      stl = (sz != 0) && !out_ready && !flush;
      add = sz + int'(in_valid);
      if (flush) begin
        q.delete();
      end else begin
        if (ret) check("retire_data", 64'(out_data), 64'(q.pop_front()));
        if (acc) q.push_back(in_data);
      end
      if (stat_clr) begin
        stall_m = 0; flush_m = 0; stall_sat_m = 0;
      end else begin
        if (stl) begin
          if (stall_m < 65535) stall_m++;
          if (stall_sat_m < 3) stall_sat_m++;
        end
        if (flush) flush_m = (flush_m + add > 65535) ? 65535 : flush_m + add;
      end
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int exp_sat[6] = '{1, 2, 3, 3, 3, 3};
    rst = 1'b1;
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    check("rst_out_valid", 64'(out_valid), 64'd0);
    check("rst_in_ready", 64'(in_ready), 64'd1);
    check("rst_occupancy", 64'(occupancy), 64'd0);
    rst = 1'b0;
    tick();

    // Streaming: 0x01..0x08 at full rate
    for (int i = 1; i <= 8; i++) begin
      drive(1'b1, DW'(i), 1'b1, 1'b0, 1'b0);
      tick();
      check("stream_data", 64'(out_data), 64'(i));
      check("stream_in_ready", 64'(in_ready), 64'd1);
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("stream_drain", 64'(occupancy), 64'd0);
    check("stream_stall", 64'(stall_cnt), 64'd0);

    // Skid fill: A flows, B arrives as out_ready drops
    drive(1'b1, 16'h0011, 1'b1, 1'b0, 1'b1);
    tick();
    check("skid_occ1", 64'(occupancy), 64'd1);
    drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    tick();
    check("skid_occ2", 64'(occupancy), 64'd2);
    check("skid_in_ready", 64'(in_ready), 64'd0);
    check("skid_stall1", 64'(stall_cnt), 64'd1);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    tick();
    check("skid_stall2", 64'(stall_cnt), 64'd2);
    tick();
    check("skid_stall3", 64'(stall_cnt), 64'd3);
    check("skid_head", 64'(out_data), 64'h11);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();
    check("skid_second", 64'(out_data), 64'h22);
    check("skid_ready_back", 64'(in_ready), 64'd1);
    tick();
    check("skid_empty", 64'(occupancy), 64'd0);

    // Flush while full with a simultaneous accept attempt
    drive(1'b1, 16'h0021, 1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b1, 16'h0022, 1'b0, 1'b0, 1'b0);
    tick();
    check("fl_pre_occ", 64'(occupancy), 64'd2);
    drive(1'b1, 16'h0033, 1'b0, 1'b1, 1'b0);
    tick();
    check("fl_occ", 64'(occupancy), 64'd0);
    check("fl_data", 64'(out_data), 64'd0);
    check("fl_in_ready", 64'(in_ready), 64'd1);
    check("fl_cnt", 64'(flush_cnt), 64'd3);
    drive(1'b1, 16'h0044, 1'b1, 1'b0, 1'b0);
    tick();
    check("fl_next_accept", 64'(out_data), 64'h44);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();

    // Saturation on the CNT_W=2 instance, then clear during a stall
    drive(1'b0, '0, 1'b0, 1'b1, 1'b1);
    tick();
    drive(1'b1, 16'h0055, 1'b0, 1'b0, 1'b0);
    tick();
    check("sat_start", 64'(s_stall_cnt), 64'd0);
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 6; i++) begin
      tick();
      check("sat_seq", 64'(s_stall_cnt), 64'(exp_sat[i]));
    end
    drive(1'b0, '0, 1'b0, 1'b0, 1'b1);
    tick();
    check("sat_clr", 64'(s_stall_cnt), 64'd0);
    check("sat_clr_main", 64'(stall_cnt), 64'd0);
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    tick();

    // Asynchronous reset with two entries held
    drive(1'b1, 16'h0066, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b1, 16'h0077, 1'b0, 1'b0, 1'b0);
    tick();
    drive(1'b0, '0, 1'b0, 1'b0, 1'b0);
    @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check("arst_out_valid", 64'(out_valid), 64'd0);
    check("arst_out_data", 64'(out_data), 64'd0);
    check("arst_in_ready", 64'(in_ready), 64'd1);
    check("arst_occ", 64'(occupancy), 64'd0);
    check("arst_stall", 64'(stall_cnt), 64'd0);
    check("arst_flush", 64'(flush_cnt), 64'd0);
    tick();
    rst = 1'b0;
    tick();

    // Random handshake soak
    for (int i = 0; i < 10000; i++) begin
      drive(1'($urandom_range(0, 1)), DW'($urandom), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 15) == 0), ($urandom_range(0, 255) == 0));
      tick();
    end
    drive(1'b0, '0, 1'b1, 1'b0, 1'b0);
    repeat (3) tick();
    check("soak_drain", 64'(occupancy), 64'd0);
    check("soak_flush_cnt", 64'(flush_cnt), 64'(flush_m));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/pipe_stage_skid.md
# pipe_stage_skid

Parametrised pipeline stage register with a valid/ready handshake, a two-entry skid buffer, synchronous flush, and saturating stall/flush statistics. It replaces the enable-gated stage latches between pipeline stages (fetch/decode/execute/memory). Full throughput is kept under backpressure, and `in_ready` is registered so no combinational path runs from `out_ready` upstream. The payload is opaque: callers concatenate imm/rs1/rs2/rd/pc/funct3/flags/acc_size into `in_data`.

## Interface
Parameters:
- DATA_W, 96, payload width in bits (≥1)
- CNT_W, 16, width of each statistics counter (≥2)

Ports:
- clk  input  1  single clock, all state updates on rising edge
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  upstream holds valid payload
- in_ready  output  1  stage can accept; registered, equals !skid_full
- in_data  input  DATA_W  upstream payload
- out_valid  output  1  main register holds valid payload
- out_ready  input  1  downstream accepts this cycle
- out_data  output  DATA_W  main register contents; all-zero whenever out_valid=0
- flush  input  1  synchronous kill of all held entries (squash/bubble)
- stat_clr  input  1  synchronous clear of both counters
- occupancy  output  2  entries held: 0, 1 or 2
- stall_cnt  output  CNT_W  cycles with out_valid & !out_ready, saturating
- flush_cnt  output  CNT_W  entries discarded by flush, saturating

## Operation
- Storage: main register (drives out_data) and skid register. State is EMPTY (occ 0), ONE (occ 1), or TWO (occ 2).
- A transfer occurs on `in_valid & in_ready` (accept) or `out_valid & out_ready` (retire).
- EMPTY:
  - accept: main←in_data, go to ONE.
  - Otherwise stay.
- ONE:
  - accept & retire: main←in_data, stay in ONE.
  - accept only: skid←in_data, go to TWO.
  - retire only: main←0, go to EMPTY.
  - Neither: hold.
- TWO (in_ready=0):
  - retire: main←skid, skid←0, go to ONE.
  - Otherwise hold.
- Ordering: strict FIFO. The skid entry is always younger than the main entry.
- Flush has highest priority:
  - Next state is EMPTY; main and skid are set to 0.
  - Any accept attempted in the flush cycle is discarded.
  - flush_cnt += current occupancy plus 1 if an accept was attempted that cycle. Saturating add, clamps at 2^CNT_W−1.
- Counters:
  - stall_cnt increments by 1 in each cycle where out_valid & !out_ready & !flush. It clamps at all-ones.
  - stat_clr sets both counters to 0 and overrides any increment in the same cycle.
- Outputs:
  - in_ready = (state != TWO), taken from registered state only.
  - out_valid = (state != EMPTY).
  - occupancy is encoded from state.

## Timing
- Reset (async assert, sync-to-clk deassert by the integrator):
  - state EMPTY, main=0, skid=0.
  - out_valid=0, out_data=0, in_ready=1.
  - occupancy=0, stall_cnt=0, flush_cnt=0.
- Latency: payload accepted at edge N is on out_data/out_valid after edge N when the stage was EMPTY, or was ONE with a simultaneous retire.
- Throughput: 1 transfer/cycle sustained with out_ready=1.
- Backpressure:
  - The first stall cycle absorbs one extra entry into skid.
  - in_ready falls one cycle after out_ready falls while input was flowing.
  - in_ready rises the cycle after the first retire from TWO.
- Flush: at the following edge out_valid=0, occupancy=0, in_ready=1. There is no dead cycle; an accept is possible in the cycle right after flush.
- Reset mid-operation: all entries lost immediately and asynchronously; counters cleared.
- No combinational path from in_valid, in_data or out_ready to any output.

## Test plan
- Reset/idle:
  - Stimulus: assert rst mid-transfer.
  - Required: out_valid=0, out_data=0, in_ready=1, occupancy=0 and both counters 0 without waiting for a clock edge.
- Streaming:
  - Stimulus: 8 consecutive payloads 0x01..0x08 with out_ready=1.
  - Required: appear on out_data in order, one per cycle, 1-cycle latency; in_ready stays 1; stall_cnt=0.
- Skid fill:
  - Stimulus: payloads A=0x11, B=0x22 back-to-back with out_ready=0 from the B cycle on.
  - Required: occupancy goes 1 then 2; in_ready=0 after B is accepted; stall_cnt increments each held cycle.
  - Then raise out_ready: outputs A then B, in_ready returns to 1 one cycle after A retires.
- Flush while full:
  - Stimulus: occupancy=2, assert flush together with in_valid=1 (payload 0x33).
  - Required: at the next edge occupancy=0, out_data=0, 0x33 never emitted, flush_cnt=3.
  - The next payload 0x44 is accepted the following cycle.
- Saturation/clear:
  - Stimulus: CNT_W=2, hold out_valid=1 & out_ready=0 for 6 cycles.
  - Required: stall_cnt reads 1,2,3,3,3,3.
  - Stimulus: stat_clr asserted during a stall cycle. Required: stall_cnt=0 the next cycle.
- Random handshake soak:
  - Stimulus: random in_valid/out_ready/flush, ≥10k cycles.
  - Required: scoreboard shows FIFO order with no duplication or loss except flushed entries; flush_cnt equals the scoreboard count of discarded entries.
